scene_controller: RTL and testbench
===================================

# scene_controller

Sequences the game's screen modes (attract, play, game over) and composites the per-pixel palette index from the background RAM, title RAM and sprite layer. It sits between the layer address generators (background, title, sprite) and the palette/VGA output stage. It also absorbs the one-cycle read latency of the layer RAMs.

## Interface
Parameters:
- BLINK_FRAMES, 8'd30: frames per title blink half-period in ATTRACT (valid range 1–255).
- OVER_FRAMES, 8'd180: frames spent in OVER before returning to ATTRACT (valid range 1–255).
- TRANSPARENT_IDX, 4'h0: palette index treated as transparent for the title and sprite layers.

Ports:
- Clk, in, 1: pixel clock. This is the one clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_clk, in, 1: vsync-derived frame strobe, synchronous to Clk. Only its rising edge is used.
- start_key, in, 1: start button, already synchronized to Clk. Only its rising edge is used.
- game_over, in, 1: level from game logic.
- is_title, in, 1: title window hit, same cycle as DrawX/DrawY.
- is_sprite, in, 1: sprite window hit, same cycle as DrawX/DrawY.
- title_address, in, 4: title RAM data, one cycle after DrawX/DrawY.
- sprite_address, in, 4: sprite RAM data, one cycle after DrawX/DrawY.
- background_address, in, 4: background RAM data, one cycle after DrawX/DrawY.
- scene, out, 2: 2'd0 ATTRACT, 2'd1 PLAY, 2'd2 OVER.
- sprite_en, out, 1: high in PLAY and OVER. Game logic freezes movement when scene≠PLAY.
- palette_index, out, 4: composited colour index.

## Operation
- Frame tick:
  - frame_tick is a one-cycle pulse on the rising edge of frame_clk, from a registered previous value.
  - All scene transitions and frame counters advance only on frame_tick.
- Start latch:
  - A start_key rising edge sets start_pend.
  - start_pend is consumed (cleared) on the next frame_tick.
  - If the edge and frame_tick land in the same cycle, the edge counts for that tick.
  - start_pend is cleared whenever the FSM is not in ATTRACT.
- FSM, evaluated on frame_tick:
  - ATTRACT: if start_pend (or a same-cycle edge), go to PLAY. Otherwise blink_cnt increments. When blink_cnt reaches BLINK_FRAMES−1, it wraps to 0 and blink_on toggles.
  - PLAY: if game_over is high, go to OVER and clear over_cnt. start_key is ignored.
  - OVER: over_cnt increments. When over_cnt reaches OVER_FRAMES−1, go to ATTRACT with blink_cnt=0 and blink_on=1. start_key is ignored and does not set start_pend.
  - Encoding 2'd3 is illegal and recovers to ATTRACT on the next Clk edge.
- Title visibility (show_title):
  - ATTRACT: blink_on.
  - OVER: 1.
  - PLAY: 0.
- Pixel path:
  - is_title and is_sprite are registered for one cycle (title_d, sprite_d) so they align with the RAM data.
  - Priority, highest first:
    1. Sprite: sprite_en & sprite_d & sprite_address≠TRANSPARENT_IDX.
    2. Title: show_title & title_d & title_address≠TRANSPARENT_IDX.
    3. Background: background_address. The background is never transparent.
  - The selected value is registered into palette_index.
- Counters are 8-bit and saturate-free: they wrap only as described above.

## Timing
- Reset values:
  - scene=ATTRACT, sprite_en=0, palette_index=4'h0.
  - blink_on=1, blink_cnt=0, over_cnt=0.
  - start_pend=0, title_d=0, sprite_d=0.
  - The frame_clk and start_key edge-detect registers reset to 0.
- Pixel latency:
  - DrawX/DrawY in cycle N, RAM data in N+1, palette_index valid in N+2.
  - Throughput is one pixel per cycle with no stalls.
- Scene update:
  - scene changes on the Clk edge that samples frame_tick=1.
  - The new show_title and sprite_en apply to the pixel composited in that same cycle.
  - Mid-frame visibility therefore never changes except at the frame_clk edge.
- game_over must be high in the frame_tick cycle to be seen. Pulses between ticks are missed by design; game logic holds the level.
- Reset_n asserted mid-operation clears everything at once, asynchronously. Deassertion takes effect synchronously on the next Clk edge.

## Configuration
- TITLE_BLINK_EN:
  - Defined: ATTRACT blinks the title as described.
  - Undefined: blink_on is tied to 1, blink_cnt is removed, and the title shows steadily in ATTRACT. BLINK_FRAMES is then unused.

## Test plan
- Reset: hold Reset_n=0 with random inputs -> scene=0, sprite_en=0, palette_index=0. Release, then on the first frame_tick -> still ATTRACT.
- Start: pulse start_key mid-frame with BLINK_FRAMES=30 -> scene stays 0 until the next frame_clk edge, then goes to 1 and sprite_en=1. An edge coincident with frame_tick also enters PLAY on that tick.
- Blink: with TITLE_BLINK_EN and BLINK_FRAMES=2, is_title=1, title_address=4'h5, background=4'h3 -> palette_index alternates 5 and 3 every 2 frames. Without the macro -> constant 5.
- Game over:
  - In PLAY, game_over=1 at a tick -> scene=2.
  - With OVER_FRAMES=3, three ticks later -> scene=0.
  - A start_key edge during OVER is ignored.
- Priority/latency in PLAY:
  - is_sprite=1, sprite_address=4'h9 -> palette_index=9 two cycles after the flag.
  - sprite_address=4'h0 (transparent) -> background value, since the title is hidden in PLAY.
- Reset_n pulsed low in OVER with over_cnt=2 -> scene returns to 0 immediately and over_cnt=0.

Source files
------------

// File: rtl/scene_controller.sv
// Screen-mode sequencer (ATTRACT/PLAY/OVER) and per-pixel layer compositor.
// Optional macro TITLE_BLINK_EN enables the blinking title in ATTRACT.
module scene_controller #(
  parameter logic [7:0] BLINK_FRAMES    = 8'd30,
  parameter logic [7:0] OVER_FRAMES     = 8'd180,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       game_over,
  input  logic       is_title,
  input  logic       is_sprite,
  input  logic [3:0] title_address,
  input  logic [3:0] sprite_address,
  input  logic [3:0] background_address,
  output logic [1:0] scene,
  output logic       sprite_en,
  output logic [3:0] palette_index
);

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    PLAY    = 2'd1,
    OVER    = 2'd2,
    ILLEGAL = 2'd3
  } scene_t;

  scene_t     state_r, state_nxt;
  logic       frame_prev_r, start_prev_r;
  logic       frame_tick_s, start_edge_s;
  logic       start_pend_r, start_pend_nxt;
  logic [7:0] over_cnt_r, over_cnt_nxt;
  logic       blink_on_r, blink_on_nxt;
  logic       title_d_r, sprite_d_r;
  logic       sprite_en_nxt, show_title_s;
  logic [3:0] pixel_s;
`ifdef TITLE_BLINK_EN
  logic [7:0] blink_cnt_r, blink_cnt_nxt;
`endif

  assign frame_tick_s = frame_clk & ~frame_prev_r;
  assign start_edge_s = start_key & ~start_prev_r;
  assign scene        = state_r;

  // Next-state and frame-counter logic; everything advances only on frame_tick.
  always_comb begin
    state_nxt      = state_r;
    over_cnt_nxt   = over_cnt_r;
    blink_on_nxt   = blink_on_r;
    start_pend_nxt = 1'b0;
`ifdef TITLE_BLINK_EN
    blink_cnt_nxt  = blink_cnt_r;
`endif
    case (state_r)
      ATTRACT: begin
        if (frame_tick_s) begin
          if (start_pend_r || start_edge_s) begin
            state_nxt = PLAY;
          end else begin
`ifdef TITLE_BLINK_EN
            if (blink_cnt_r == BLINK_FRAMES - 8'd1) begin
              blink_cnt_nxt = 8'd0;
              blink_on_nxt  = ~blink_on_r;
            end else begin
              blink_cnt_nxt = blink_cnt_r + 8'd1;
            end
`else
            blink_on_nxt = (BLINK_FRAMES != 8'd0) | 1'b1;
`endif
          end
        end else begin
          start_pend_nxt = start_pend_r | start_edge_s;
        end
      end
      PLAY: begin
        if (frame_tick_s && game_over) begin
          state_nxt    = OVER;
          over_cnt_nxt = 8'd0;
        end else begin
          state_nxt = PLAY;
        end
      end
      OVER: begin
        if (frame_tick_s) begin
          if (over_cnt_r == OVER_FRAMES - 8'd1) begin
            state_nxt    = ATTRACT;
            blink_on_nxt = 1'b1;
`ifdef TITLE_BLINK_EN
            blink_cnt_nxt = 8'd0;
`endif
          end else begin
            over_cnt_nxt = over_cnt_r + 8'd1;
          end
        end else begin
          state_nxt = OVER;
        end
      end
      default: state_nxt = ATTRACT;
    endcase
  end

  // Layer priority uses the post-tick scene so visibility switches exactly at the frame edge.
  always_comb begin
    sprite_en_nxt = (state_nxt == PLAY) || (state_nxt == OVER);
    show_title_s  = (state_nxt == OVER) || ((state_nxt == ATTRACT) && blink_on_nxt);
    if (sprite_en_nxt && sprite_d_r && (sprite_address != TRANSPARENT_IDX)) begin
      pixel_s = sprite_address;
    end else if (show_title_s && title_d_r && (title_address != TRANSPARENT_IDX)) begin
      pixel_s = title_address;
    end else begin
      pixel_s = background_address;
    end
  end

  // State, counters, edge detectors and the pixel pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ATTRACT;
      frame_prev_r  <= 1'b0;
      start_prev_r  <= 1'b0;
      start_pend_r  <= 1'b0;
      over_cnt_r    <= 8'd0;
      blink_on_r    <= 1'b1;
      title_d_r     <= 1'b0;
      sprite_d_r    <= 1'b0;
      sprite_en     <= 1'b0;
      palette_index <= 4'h0;
`ifdef TITLE_BLINK_EN
      blink_cnt_r   <= 8'd0;
`endif
    end else begin
      state_r       <= state_nxt;
      frame_prev_r  <= frame_clk;
      start_prev_r  <= start_key;
      start_pend_r  <= start_pend_nxt;
      over_cnt_r    <= over_cnt_nxt;
      blink_on_r    <= blink_on_nxt;
      title_d_r     <= is_title;
      sprite_d_r    <= is_sprite;
      sprite_en     <= sprite_en_nxt;
      palette_index <= pixel_s;
`ifdef TITLE_BLINK_EN
      blink_cnt_r   <= blink_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_scene_controller.sv
// Randomized bench for scene_controller against a frame-count based reference model.
module tb_scene_controller;
  localparam int BLINK_F = 2;
  localparam int OVER_F  = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_clk = 1'b0, start_key = 1'b0, game_over = 1'b0;
  logic       is_title = 1'b0, is_sprite = 1'b0;
  logic [3:0] title_address = 4'h0, sprite_address = 4'h0, background_address = 4'h0;
  logic [1:0] scene;
  logic       sprite_en;
  logic [3:0] palette_index;

  scene_controller #(.BLINK_FRAMES(8'd2), .OVER_FRAMES(8'd3), .TRANSPARENT_IDX(4'h0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start_key(start_key),
    .game_over(game_over), .is_title(is_title), .is_sprite(is_sprite),
    .title_address(title_address), .sprite_address(sprite_address),
    .background_address(background_address), .scene(scene), .sprite_en(sprite_en),
    .palette_index(palette_index)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: scene plus plain frame counts since the relevant mode began.
  int m_scene, m_attract_frames, m_over_ticks;
  bit m_pend, m_fprev, m_sprev, m_title_d, m_sprite_d;
  int exp_scene, exp_en, exp_pal;

  bit         rnd_pix = 1'b1;
  logic       p_title_f = 1'b0, p_sprite_f = 1'b0;
  logic [3:0] p_title = 4'h0, p_sprite = 4'h0, p_bg = 4'h0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scene = 0; m_attract_frames = 0; m_over_ticks = 0;
    m_pend = 0; m_fprev = 0; m_sprev = 0; m_title_d = 0; m_sprite_d = 0;
    exp_scene = 0; exp_en = 0; exp_pal = 0;
  endtask

  function automatic bit blink_visible(input int frames);
`ifdef TITLE_BLINK_EN
    return ((frames / BLINK_F) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step();
    bit tick, sedge, show, sp_hit, ti_hit;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    tick  = frame_clk && !m_fprev;
    sedge = start_key && !m_sprev;
    if (m_scene == 0) begin
      if (tick && (m_pend || sedge)) m_scene = 1;
      else if (tick) m_attract_frames++;
      m_pend = tick ? 1'b0 : (m_pend || sedge);
    end else if (m_scene == 1) begin
      m_pend = 0;
      if (tick && game_over) begin m_scene = 2; m_over_ticks = 0; end
    end else begin
      m_pend = 0;
      if (tick) begin
        if (m_over_ticks + 1 == OVER_F) begin m_scene = 0; m_attract_frames = 0; end
        else m_over_ticks++;
      end
    end
    exp_scene = m_scene;
    exp_en    = (m_scene != 0);
    show      = (m_scene == 2) || (m_scene == 0 && blink_visible(m_attract_frames));
    sp_hit    = exp_en && m_sprite_d && (sprite_address != 4'h0);
    ti_hit    = show && m_title_d && (title_address != 4'h0);
    exp_pal   = sp_hit ? int'(sprite_address) : (ti_hit ? int'(title_address) : int'(background_address));
    m_fprev = frame_clk; m_sprev = start_key;
    m_title_d = is_title; m_sprite_d = is_sprite;
  endtask

  task automatic cyc(input logic fc, input logic sk, input logic go);
    frame_clk = fc; start_key = sk; game_over = go;
    if (rnd_pix) begin
      is_title = 1'($urandom_range(0, 1)); is_sprite = 1'($urandom_range(0, 1));
      title_address = 4'($urandom_range(0, 15)); sprite_address = 4'($urandom_range(0, 15));
      background_address = 4'($urandom_range(0, 15));
    end else begin
      is_title = p_title_f; is_sprite = p_sprite_f;
      title_address = p_title; sprite_address = p_sprite; background_address = p_bg;
    end
    model_step();
    @(posedge Clk); #1;
    check("scene", int'(scene), exp_scene);
    check("sprite_en", int'(sprite_en), exp_en);
    check("palette_index", int'(palette_index), exp_pal);
  endtask

  task automatic frame_pulse(input logic sk, input logic go);
    cyc(1'b1, sk, go);
    cyc(1'b1, 1'b0, go);
    repeat (4) cyc(1'b0, 1'b0, go);
  endtask

  initial begin
    model_reset();
    #2 Reset_n = 1'b0;
    repeat (5) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("rst_scene", int'(scene), 0);
    check("rst_sprite_en", int'(sprite_en), 0);
    check("rst_palette", int'(palette_index), 0);
    Reset_n = 1'b1;

    rnd_pix = 1'b0; p_title_f = 1'b1; p_title = 4'h5; p_bg = 4'h3; p_sprite_f = 1'b0; p_sprite = 4'h0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("attract_title", int'(palette_index), 5);
    frame_pulse(1'b0, 1'b0);
    check("first_tick_attract", int'(scene), 0);
    frame_pulse(1'b0, 1'b0);
`ifdef TITLE_BLINK_EN
    check("blink_off", int'(palette_index), 3);
`else
    check("steady_title", int'(palette_index), 5);
`endif
    frame_pulse(1'b0, 1'b0);
    frame_pulse(1'b0, 1'b0);
    check("blink_on_again", int'(palette_index), 5);

    cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("start_waits_tick", int'(scene), 0);
    frame_pulse(1'b0, 1'b0);
    check("start_play", int'(scene), 1);
    check("play_sprite_en", int'(sprite_en), 1);

    p_sprite_f = 1'b1; p_sprite = 4'h9;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("sprite_prio", int'(palette_index), 9);
    p_sprite = 4'h0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("sprite_transparent", int'(palette_index), 3);

    frame_pulse(1'b0, 1'b1);
    check("game_over", int'(scene), 2);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("over_title", int'(palette_index), 5);
    frame_pulse(1'b0, 1'b0);
    frame_pulse(1'b0, 1'b0);
    check("over_hold", int'(scene), 2);
    frame_pulse(1'b0, 1'b0);
    check("over_to_attract", int'(scene), 0);
    frame_pulse(1'b0, 1'b0);
    check("over_start_ignored", int'(scene), 0);

    frame_pulse(1'b1, 1'b0);
    check("coincident_start", int'(scene), 1);

    frame_pulse(1'b0, 1'b1);
    check("game_over_2", int'(scene), 2);
    frame_pulse(1'b0, 1'b0);
    frame_pulse(1'b0, 1'b0);
    Reset_n = 1'b0;
    #1;
    check("async_rst_scene", int'(scene), 0);
    check("async_rst_en", int'(sprite_en), 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;

    rnd_pix = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic fc, sk;
      fc = ((i % 10) < 2) ? 1'b1 : 1'($urandom_range(0, 19) == 0);
      sk = 1'($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) game_over = ~game_over;
      if ($urandom_range(0, 499) == 0) Reset_n = 1'b0;
      else Reset_n = 1'b1;
      cyc(fc, sk, game_over);
    end
    Reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
